noc_packet_injector: RTL and testbench

NOC_PACKET_INJECTOR -- requirements
Module: noc_packet_injector

---
 rtl/noc_packet_injector.sv | 197 +++++++++++++++++++
 tb/tb_noc_packet_injector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// noc_packet_injector: launches one packet into a selected router slot of a flat
// NoC injection bus and holds it until that router acknowledges it. Push-button
// keys edit the router index and the payload counter, and two 7-segment digits
// show the low nibble of each.
// Optional feature macro: INJ_TIMEOUT_EN (ack-wait timeout with sticky err flag).
module noc_packet_injector #(
  parameter int unsigned N_ROUTERS = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sw_on,
  input  logic                             sw_sel_data,
  input  logic                             sw_sel_router,
  input  logic                             key_inc,
  input  logic                             key_dec,
  input  logic [N_ROUTERS-1:0]             out_ack,
  output logic [N_ROUTERS*(DATA_W+1)-1:0]  out_data,
  output logic                             busy,
  output logic [7:0]                       sent_cnt,
  output logic                             err,
  output logic [6:0]                       hex_data,
  output logic [6:0]                       hex_router
);

  localparam int unsigned SLOT_W = DATA_W + 1;
  localparam int unsigned BUS_W  = N_ROUTERS * SLOT_W;
  localparam logic [ADDR_W-1:0] ROUTER_MAX = ADDR_W'(N_ROUTERS - 1);

  // Reject illegal parameter combinations at elaboration
  if (N_ROUTERS < 2 || N_ROUTERS > 256 || (1 << ADDR_W) < N_ROUTERS || TIMEOUT < 1) begin : g_bad_param
    $error("noc_packet_injector: illegal parameter combination");
  end

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t              r_state;
  logic [2:0]          r_sync1;   // {dec, inc, on}
  logic [2:0]          r_sync2;
  logic [2:0]          r_prev;
  logic [ADDR_W-1:0]   r_router;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_snap_router;
  logic [BUS_W-1:0]    r_out_data;
  logic                r_busy;
  logic [7:0]          r_sent_cnt;
  logic [6:0]          r_hex_data;
  logic [6:0]          r_hex_router;

  logic [2:0]          w_edge;
  logic                w_on;
  logic                w_inc;
  logic                w_dec;
  logic [ADDR_W-1:0]   w_router_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [BUS_W-1:0]    w_launch_bus;
  logic                w_ack_hit;
  logic                w_timeout;

  // Active-low hex digit decode, bit6 = a ... bit0 = g
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'b0000001;
      4'h1: f_seg = 7'b1001111;
      4'h2: f_seg = 7'b0010010;
      4'h3: f_seg = 7'b0000110;
      4'h4: f_seg = 7'b1001100;
      4'h5: f_seg = 7'b0100100;
      4'h6: f_seg = 7'b0100000;
      4'h7: f_seg = 7'b0001111;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0000100;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b1100000;
      4'hC: f_seg = 7'b0110001;
      4'hD: f_seg = 7'b1000010;
      4'hE: f_seg = 7'b0110000;
      default: f_seg = 7'b0111000;
    endcase
  endfunction

  assign w_edge = r_sync2 & ~r_prev;
  assign w_on   = w_edge[0];
  assign w_inc  = w_edge[1] & ~w_edge[2];
  assign w_dec  = w_edge[2] & ~w_edge[1];
  assign w_ack_hit = out_ack[r_snap_router];

  // Next router/data values from key edges; router selection has priority
  always_comb begin
    w_router_nxt = r_router;
    w_data_nxt   = r_data;
    if (sw_sel_router) begin
      if (w_inc)      w_router_nxt = (r_router == ROUTER_MAX) ? '0 : r_router + ADDR_W'(1);
      else if (w_dec) w_router_nxt = (r_router == '0) ? ROUTER_MAX : r_router - ADDR_W'(1);
    end else if (sw_sel_data) begin
      if (w_inc)      w_data_nxt = r_data + DATA_W'(1);
      else if (w_dec) w_data_nxt = r_data - DATA_W'(1);
    end
  end

  // Slot bus image for a packet launched from the current router/data
  always_comb begin
    w_launch_bus = '0;
    for (int i = 0; i < int'(N_ROUTERS); i++) begin
      if (ADDR_W'(i) == r_router) w_launch_bus[i*SLOT_W +: SLOT_W] = {1'b1, r_data};
    end
  end

  // Input synchronizers, edge history, edit counters and display digits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_prev       <= '0;
      r_router     <= '0;
      r_data       <= '0;
      r_hex_data   <= 7'b0000001;
      r_hex_router <= 7'b0000001;
    end else begin
      r_sync1      <= {key_dec, key_inc, sw_on};
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_router     <= w_router_nxt;
      r_data       <= w_data_nxt;
      r_hex_data   <= f_seg(4'(w_data_nxt));
      r_hex_router <= f_seg(4'(w_router_nxt));
    end
  end

`ifdef INJ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] r_wait;
  logic              r_err;
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Injection FSM: IDLE launches on a sw_on edge, SEND holds until ack (or timeout)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_out_data    <= '0;
      r_busy        <= 1'b0;
      r_snap_router <= '0;
      r_sent_cnt    <= '0;
`ifdef INJ_TIMEOUT_EN
      r_wait        <= '0;
      r_err         <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_on) begin
            r_state       <= ST_SEND;
            r_busy        <= 1'b1;
            r_out_data    <= w_launch_bus;
            r_snap_router <= r_router;
`ifdef INJ_TIMEOUT_EN
            r_wait        <= '0;
`endif
          end
        end
        default: begin
          if (w_ack_hit) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_out_data <= '0;
            r_sent_cnt <= r_sent_cnt + 8'd1;
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_out_data <= '0;
`ifdef INJ_TIMEOUT_EN
            r_err      <= 1'b1;
`endif
          end else begin
`ifdef INJ_TIMEOUT_EN
            r_wait     <= r_wait + WAIT_W'(1);
`endif
          end
        end
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign sent_cnt   = r_sent_cnt;
  assign hex_data   = r_hex_data;
  assign hex_router = r_hex_router;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Testbench for noc_packet_injector: table of key-edit vectors, each followed by a
// scoreboarded packet launch/ack, plus hand sequences for in-flight edits, idle
// acks, ack timeout/no-timeout and reset while sending.
module tb_noc_packet_injector;

  localparam int NR = 64;
  localparam int AW = 6;
  localparam int DW = 14;
  localparam int SW = DW + 1;
  localparam int BW = NR * SW;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_on, sw_sel_data, sw_sel_router, key_inc, key_dec;
  logic [NR-1:0] out_ack;
  logic [BW-1:0] out_data;
  logic          busy;
  logic [7:0]    sent_cnt;
  logic          err;
  logic [6:0]    hex_data, hex_router;

  int tests = 0;
  int fails = 0;
  int m_sent = 0;
  logic [BW-1:0] sb_q[$];
  logic [BW-1:0] last_exp;

  always #5 clk = ~clk;

  noc_packet_injector #(.N_ROUTERS(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sw_on(sw_on), .sw_sel_data(sw_sel_data),
    .sw_sel_router(sw_sel_router), .key_inc(key_inc), .key_dec(key_dec),
    .out_ack(out_ack), .out_data(out_data), .busy(busy), .sent_cnt(sent_cnt),
    .err(err), .hex_data(hex_data), .hex_router(hex_router)
  );

  typedef struct {
    logic sel_r;
    logic sel_d;
    int   op;      // 0 none, 1 inc, 2 dec, 3 inc+dec together
    int   n;
    int   exp_router;
    int   exp_data;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] seg(input int v);
    case (v & 15)
      0: seg = 7'b0000001;  1: seg = 7'b1001111;  2: seg = 7'b0010010;  3: seg = 7'b0000110;
      4: seg = 7'b1001100;  5: seg = 7'b0100100;  6: seg = 7'b0100000;  7: seg = 7'b0001111;
      8: seg = 7'b0000000;  9: seg = 7'b0000100;  10: seg = 7'b0001000; 11: seg = 7'b1100000;
      12: seg = 7'b0110001; 13: seg = 7'b1000010; 14: seg = 7'b0110000; default: seg = 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge; each pulse is held 3 cycles then released 4
  task automatic pulse_key(input int op, input int n);
    for (int k = 0; k < n; k++) begin
      key_inc = (op == 1 || op == 3);
      key_dec = (op == 2 || op == 3);
      repeat (3) @(negedge clk);
      key_inc = 1'b0;
      key_dec = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // Raise sw_on, expect the packet on the 3rd posedge, then pop/compare the scoreboard
  task automatic launch(input int r, input int d);
    logic [BW-1:0] e;
    logic [DW-1:0] dd;
    dd = DW'(d);
    e = '0;
    e[r*SW +: SW] = {1'b1, dd};
    sb_q.push_back(e);
    sw_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_before_3rd_edge", busy, 1'b0);
    @(negedge clk);
    chk("busy_on_3rd_edge", busy, 1'b1);
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      last_exp = sb_q.pop_front();
      chk("slot_image", out_data, last_exp);
    end
    sw_on = 1'b0;
  endtask

  // A foreign ack must be ignored, then the correct ack retires the packet
  task automatic ack_and_check(input int r);
    out_ack = '0;
    out_ack[(r + 1) % NR] = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_after_foreign_ack", busy, 1'b1);
    chk("slot_held_after_foreign_ack", out_data, last_exp);
    out_ack = '0;
    out_ack[r] = 1'b1;
    @(negedge clk);
    out_ack = '0;
    m_sent++;
    chk("data_cleared_on_ack", out_data, '0);
    chk("busy_cleared_on_ack", busy, 1'b0);
    chk("sent_cnt", sent_cnt, 8'(m_sent));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    vecs[0] = '{1'b1, 1'b0, 1, 5, 5, 0};
    vecs[1] = '{1'b1, 1'b0, 2, 6, 63, 0};
    vecs[2] = '{1'b1, 1'b0, 1, 1, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 2, 1, 0, 16383};
    vecs[4] = '{1'b0, 1'b1, 1, 4, 0, 3};
    vecs[5] = '{1'b1, 1'b1, 1, 2, 2, 3};
    vecs[6] = '{1'b0, 1'b0, 1, 3, 2, 3};
    vecs[7] = '{1'b0, 1'b1, 3, 1, 2, 3};

    rst = 1'b1; sw_on = 1'b0; sw_sel_data = 1'b0; sw_sel_router = 1'b0;
    key_inc = 1'b0; key_dec = 1'b0; out_ack = '0; last_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent_cnt", sent_cnt, 8'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_hex_data", hex_data, 7'b0000001);
    chk("rst_hex_router", hex_router, 7'b0000001);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      sw_sel_router = vecs[i].sel_r;
      sw_sel_data   = vecs[i].sel_d;
      pulse_key(vecs[i].op, vecs[i].n);
      chk("vec_hex_router", hex_router, seg(vecs[i].exp_router));
      chk("vec_hex_data", hex_data, seg(vecs[i].exp_data));
      launch(vecs[i].exp_router, vecs[i].exp_data);
      ack_and_check(vecs[i].exp_router);
    end

    // Edits and a second sw_on edge while in flight
    sw_sel_router = 1'b0;
    sw_sel_data   = 1'b1;
    launch(2, 3);
    repeat (4) @(negedge clk);
    sw_on = 1'b1;
    pulse_key(1, 3);
    sw_on = 1'b0;
    chk("inflight_hex_data", hex_data, seg(6));
    chk("inflight_busy", busy, 1'b1);
    chk("inflight_slot_unchanged", out_data, last_exp);
    out_ack[2] = 1'b1;
    @(negedge clk);
    out_ack = '0;
    m_sent++;
    chk("inflight_ack_idle", busy, 1'b0);
    repeat (6) @(negedge clk);
    chk("second_on_ignored", busy, 1'b0);

    // Acks while idle are ignored
    out_ack = '1;
    repeat (4) @(negedge clk);
    out_ack = '0;
    chk("idle_ack_sent_cnt", sent_cnt, 8'(m_sent));
    chk("idle_ack_busy", busy, 1'b0);

    // No ack: timeout build returns after TO cycles, default build waits
    launch(2, 6);
    n_busy = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (busy) n_busy++;
    end
`ifdef INJ_TIMEOUT_EN
    chk("timeout_send_cycles", 32'(n_busy), 32'(TO));
    chk("timeout_err", err, 1'b1);
    chk("timeout_data_cleared", out_data, '0);
    chk("timeout_sent_cnt", sent_cnt, 8'(m_sent));
`else
    chk("no_timeout_send_cycles", 32'(n_busy), 32'd15);
    chk("no_timeout_err", err, 1'b0);
    chk("no_timeout_slot_held", out_data, last_exp);
    out_ack[2] = 1'b1;
    @(negedge clk);
    out_ack = '0;
    m_sent++;
    chk("late_ack_sent_cnt", sent_cnt, 8'(m_sent));
`endif
    repeat (4) @(negedge clk);

    // Reset while sending drops the packet and clears counters
    launch(2, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_sent = 0;
    chk("rst_send_out_data", out_data, '0);
    chk("rst_send_busy", busy, 1'b0);
    chk("rst_send_sent_cnt", sent_cnt, 8'd0);
    chk("rst_send_err", err, 1'b0);
    chk("rst_send_hex_data", hex_data, 7'b0000001);
    chk("rst_send_hex_router", hex_router, 7'b0000001);
    repeat (3) @(negedge clk);
    launch(0, 0);
    ack_and_check(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
